// File: rtl/mux17_sel_sequencer.sv
// Select-stream sequencer for one mux_17to1_module lane: turns a nonzero mask into
// a fixed-length burst of select codes, lowest set bit first, zero code for spare slots.
module mux17_sel_sequencer #(
  parameter int unsigned NUM_IN    = 16,
  parameter int unsigned SEL_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_IN-1:0]    in_mask,
  input  logic [SEL_WIDTH-1:0] in_budget,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_WIDTH-1:0] out_sel,
  output logic                 out_last,
  output logic                 drop
);

  localparam logic [SEL_WIDTH-1:0] ZERO_SEL = SEL_WIDTH'(1) << (SEL_WIDTH - 1);

  typedef enum logic [0:0] {IDLE, ISSUE} state_t;

  state_t                 state;
  logic [NUM_IN-1:0]      rem;
  logic [SEL_WIDTH-1:0]   budget;
  logic [SEL_WIDTH-1:0]   slot;

  logic                   fire;
  logic                   accept;
  logic [NUM_IN-1:0]      rem_cleared;
  logic [SEL_WIDTH-1:0]   budget_eff;
  logic [SEL_WIDTH-1:0]   sel_c;

  // Lowest set bit of the pending mask, or the zero code when nothing is pending.
  always_comb begin
    sel_c = ZERO_SEL;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rem[i]) sel_c = SEL_WIDTH'(i);
    end
  end

  assign out_sel     = sel_c;
  assign out_valid   = (state == ISSUE);
  assign out_last    = (state == ISSUE) && (slot == budget - SEL_WIDTH'(1));
  assign in_ready    = (state == IDLE) || (out_last && out_ready);
  assign fire        = out_valid && out_ready;
  assign accept      = in_valid && in_ready;
  assign rem_cleared = rem & (rem - NUM_IN'(1));
  assign budget_eff  = (in_budget == '0) ? SEL_WIDTH'(1) : in_budget;

  // Burst state: a new entry accepted on the last beat overrides the end-of-burst clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      budget <= '0;
      slot   <= '0;
      drop   <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (fire) begin
        if (out_last) begin
          drop  <= |rem_cleared;
          state <= IDLE;
          rem   <= '0;
          slot  <= '0;
        end else begin
          rem  <= rem_cleared;
          slot <= slot + SEL_WIDTH'(1);
        end
      end
      if (accept) begin
        state  <= ISSUE;
        rem    <= in_mask;
        budget <= budget_eff;
        slot   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux17_sel_sequencer.sv
// Directed bench for mux17_sel_sequencer: hand-computed select streams, outputs
// sampled 1 time unit after each rising edge.
module tb_mux17_sel_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_mask;
  logic [4:0]  in_budget;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_sel;
  logic        out_last;
  logic        drop;

  int checks = 0;
  int errors = 0;

  mux17_sel_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_budget (in_budget),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [4:0] sel, input logic last);
    check({tag, " valid"}, 32'(out_valid), 32'd1);
    check({tag, " sel"},   32'(out_sel),   32'(sel));
    check({tag, " last"},  32'(out_last),  32'(last));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mask   = '0;
    in_budget = '0;
    out_ready = 1'b1;

    // Reset values
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_sel",   32'(out_sel),   32'd16);
    check("rst in_ready",  32'(in_ready),  32'd1);
    check("rst drop",      32'(drop),      32'd0);
    check("rst out_last",  32'(out_last),  32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // mask 0x0005, budget 4: 0,2,16,16
    in_valid = 1'b1; in_mask = 16'h0005; in_budget = 5'd4;
    step();
    in_valid = 1'b0; in_mask = 16'hFFFF; in_budget = 5'd1;
    beat("t2 b1", 5'd0, 1'b0);
    step(); beat("t2 b2", 5'd2,  1'b0);
    step(); beat("t2 b3", 5'd16, 1'b0);
    step(); beat("t2 b4", 5'd16, 1'b1);
    step();
    check("t2 idle", 32'(out_valid), 32'd0);
    check("t2 drop", 32'(drop),      32'd0);

    // mask 0xFFFF, budget 3: 0,1,2 then drop pulse
    in_valid = 1'b1; in_mask = 16'hFFFF; in_budget = 5'd3;
    step();
    in_valid = 1'b0;
    beat("t3 b1", 5'd0, 1'b0);
    step(); beat("t3 b2", 5'd1, 1'b0);
    step(); beat("t3 b3", 5'd2, 1'b1);
    step();
    check("t3 drop",  32'(drop),      32'd1);
    check("t3 idle",  32'(out_valid), 32'd0);
    step();
    check("t3 drop clr", 32'(drop), 32'd0);

    // mask 0x8001, budget 2 with backpressure on beat 1
    in_valid = 1'b1; in_mask = 16'h8001; in_budget = 5'd2;
    step();
    in_valid = 1'b0;
    beat("t4 b1", 5'd0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      beat("t4 hold", 5'd0, 1'b0);
    end
    out_ready = 1'b1;
    step(); beat("t4 b2", 5'd15, 1'b1);
    step();
    check("t4 idle", 32'(out_valid), 32'd0);
    check("t4 drop", 32'(drop),      32'd0);

    // Back-to-back bursts, no bubble; budget 0 gives one beat
    in_valid = 1'b1; in_mask = 16'h0002; in_budget = 5'd1;
    step();
    beat("t5 a1", 5'd1, 1'b1);
    check("t5 in_ready", 32'(in_ready), 32'd1);
    in_mask = 16'h0000; in_budget = 5'd2;
    step();
    in_valid = 1'b0;
    beat("t5 b1", 5'd16, 1'b0);
    step();
    beat("t5 b2", 5'd16, 1'b1);
    in_valid = 1'b1; in_mask = 16'h0010; in_budget = 5'd0;
    step();
    in_valid = 1'b0;
    beat("t5 c1", 5'd4, 1'b1);
    step();
    check("t5 idle", 32'(out_valid), 32'd0);
    check("t5 drop", 32'(drop),      32'd0);

    // Reset during beat 2 of a 4-slot burst
    in_valid = 1'b1; in_mask = 16'h000F; in_budget = 5'd4;
    step();
    in_valid = 1'b0;
    beat("t6 b1", 5'd0, 1'b0);
    step();
    beat("t6 b2", 5'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6 rst valid", 32'(out_valid), 32'd0);
    check("t6 rst sel",   32'(out_sel),   32'd16);
    check("t6 rst ready", 32'(in_ready),  32'd1);
    check("t6 rst drop",  32'(drop),      32'd0);
    step();
    check("t6 rst drop2", 32'(drop), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; in_mask = 16'h0008; in_budget = 5'd2;
    step();
    in_valid = 1'b0;
    beat("t6 n1", 5'd3,  1'b0);
    step();
    beat("t6 n2", 5'd16, 1'b1);
    step();
    check("t6 idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
